// File: rtl/corevx_store_buffer.sv
// corevx_store_buffer
// In-order store buffer between store generation and the data memory port.
// Stores are queued in a circular FIFO and drained one at a time; loads whose
// word address and byte lanes overlap any pending store raise loadHazard.
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid and ready are both high. The producer holds its payload stable while
// valid is high and ready is low. enqReady depends only on the stored count,
// and memValid only on emptiness, so neither ready nor valid is combinationally
// derived from the other side of the same interface.

module corevx_store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       enqValid,
    output logic                       enqReady,
    input  logic [ADDR_W-1:0]          enqAddress,
    input  logic [31:0]                enqData,
    input  logic [3:0]                 enqMask,

    output logic                       memValid,
    input  logic                       memReady,
    output logic [ADDR_W-1:0]          memAddress,
    output logic [31:0]                memData,
    output logic [3:0]                 memMask,

    input  logic [ADDR_W-1:0]          loadCheckAddress,
    input  logic [3:0]                 loadCheckMask,
    output logic                       loadHazard,

    output logic                       bufEmpty,
    output logic [$clog2(DEPTH+1)-1:0] bufCount
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int WA_W  = ADDR_W - 2;

    // Entry storage: word address, lane-shifted data, byte mask.
    logic [WA_W-1:0]  addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [3:0]       mask_q [DEPTH];
    logic [DEPTH-1:0] valid_q;

    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_next;

    logic enq_fire;
    logic enq_stored;
    logic deq_fire;
    logic hazard;

    // Byte-offset bits of both addresses are ignored by design.
    logic unused_low_bits;
    assign unused_low_bits = ^{enqAddress[1:0], loadCheckAddress[1:0]};

    // Handshake decode and status flags, all derived from registered count.
    always_comb begin
        enqReady   = (count_q != CNT_W'(DEPTH));
        bufEmpty   = (count_q == '0);
        memValid   = !bufEmpty;
        enq_fire   = enqValid && enqReady;
        // A zero mask completes the handshake but carries no bytes to write.
        enq_stored = enq_fire && (enqMask != 4'b0000);
        deq_fire   = memValid && memReady;
        count_next = count_q + CNT_W'(enq_stored) - CNT_W'(deq_fire);
    end

    // Pointers, count and entry-valid bits; reset drops every pending store.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            // head==tail only when empty or full, so the set and clear below
            // can never target the same entry in one cycle.
            if (enq_stored) begin
                valid_q[tail_ptr] <= 1'b1;
                tail_ptr          <= tail_ptr + PTR_W'(1);
            end
            if (deq_fire) begin
                valid_q[head_ptr] <= 1'b0;
                head_ptr          <= head_ptr + PTR_W'(1);
            end
            count_q <= count_next;
        end
    end

    // Entry payload writes; payload is qualified by valid_q so needs no reset.
    always_ff @(posedge clk) begin
        if (enq_stored) begin
            addr_q[tail_ptr] <= enqAddress[ADDR_W-1:2];
            data_q[tail_ptr] <= enqData;
            mask_q[tail_ptr] <= enqMask;
        end
    end

    // Memory side presents the registered head entry; no bypass from enq*.
    always_comb begin
        memAddress = {addr_q[head_ptr], 2'b00};
        memData    = data_q[head_ptr];
        memMask    = mask_q[head_ptr];
    end

    // Overlap check against every valid entry, head included; a store being
    // enqueued this cycle is not yet valid and so cannot contribute.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i]
                && (addr_q[i] == loadCheckAddress[ADDR_W-1:2])
                && ((mask_q[i] & loadCheckMask) != 4'b0000)) begin
                hazard = 1'b1;
            end
        end
    end

    assign loadHazard = hazard;
    assign bufCount   = count_q;

endmodule

// File: tb/tb_corevx_store_buffer.sv
// Self-checking bench for corevx_store_buffer: directed scenarios followed by
// randomized traffic compared against a queue-based reference model.

module tb_corevx_store_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;

  typedef struct packed {
    logic [ADDR_W-3:0] waddr;
    logic [31:0]       data;
    logic [3:0]        mask;
  } entry_t;

  logic              clk;
  logic              rst;
  logic              enqValid;
  logic              enqReady;
  logic [ADDR_W-1:0] enqAddress;
  logic [31:0]       enqData;
  logic [3:0]        enqMask;
  logic              memValid;
  logic              memReady;
  logic [ADDR_W-1:0] memAddress;
  logic [31:0]       memData;
  logic [3:0]        memMask;
  logic [ADDR_W-1:0] loadCheckAddress;
  logic [3:0]        loadCheckMask;
  logic              loadHazard;
  logic              bufEmpty;
  logic [2:0]        bufCount;

  int checks;
  int failures;

  // scoreboard: pending stores, oldest first
  entry_t exp_q[$];

  corevx_store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk),
    .rst(rst),
    .enqValid(enqValid),
    .enqReady(enqReady),
    .enqAddress(enqAddress),
    .enqData(enqData),
    .enqMask(enqMask),
    .memValid(memValid),
    .memReady(memReady),
    .memAddress(memAddress),
    .memData(memData),
    .memMask(memMask),
    .loadCheckAddress(loadCheckAddress),
    .loadCheckMask(loadCheckMask),
    .loadHazard(loadHazard),
    .bufEmpty(bufEmpty),
    .bufCount(bufCount)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // reference hazard: any pending store on the same word sharing a byte lane
  function automatic logic model_hazard(input logic [ADDR_W-1:0] a, input logic [3:0] m);
    logic h;
    h = 1'b0;
    foreach (exp_q[i])
      if (exp_q[i].waddr == a[ADDR_W-1:2] && (exp_q[i].mask & m) != 4'b0000) h = 1'b1;
    return h;
  endfunction

  // driver: idle all inputs
  task automatic drive_idle();
    enqValid         = 1'b0;
    enqAddress       = '0;
    enqData          = '0;
    enqMask          = '0;
    memReady         = 1'b0;
    loadCheckAddress = '0;
    loadCheckMask    = '0;
  endtask

  // driver: present a store
  task automatic drive_enq(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] m);
    enqValid   = 1'b1;
    enqAddress = a;
    enqData    = d;
    enqMask    = m;
  endtask

  // advance one clock; the model applies the handshakes seen at this edge
  task automatic tick();
    bit do_deq;
    bit do_enq;
    entry_t e;
    do_deq  = memReady && (exp_q.size() > 0);
    do_enq  = enqValid && (exp_q.size() < DEPTH);
    e.waddr = enqAddress[ADDR_W-1:2];
    e.data  = enqData;
    e.mask  = enqMask;
    @(posedge clk);
    if (rst) exp_q.delete();
    else begin
      if (do_deq) void'(exp_q.pop_front());
      if (do_enq && e.mask != 4'b0000) exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++; if (memValid !== 1'b0) begin failures++; $display("FAIL reset_memValid got=%b exp=0", memValid); end
    checks++; if (bufEmpty !== 1'b1) begin failures++; $display("FAIL reset_bufEmpty got=%b exp=1", bufEmpty); end
    checks++; if (bufCount !== 3'd0) begin failures++; $display("FAIL reset_bufCount got=%0d exp=0", bufCount); end
    checks++; if (enqReady !== 1'b1) begin failures++; $display("FAIL reset_enqReady got=%b exp=1", enqReady); end
    checks++; if (loadHazard !== 1'b0) begin failures++; $display("FAIL reset_loadHazard got=%b exp=0", loadHazard); end
  endtask

  task automatic test_single();
    drive_idle();
    drive_enq(32'h1000_0006, 32'hABCD_0000, 4'b1100);
    #1;
    checks++; if (memValid !== 1'b0) begin failures++; $display("FAIL single_no_bypass got=%b exp=0", memValid); end
    tick();
    enqValid = 1'b0;
    #1;
    checks++; if (memValid !== 1'b1) begin failures++; $display("FAIL single_memValid got=%b exp=1", memValid); end
    checks++; if (memAddress !== 32'h1000_0004) begin failures++; $display("FAIL single_memAddress got=%h exp=10000004", memAddress); end
    checks++; if (memData !== 32'hABCD_0000) begin failures++; $display("FAIL single_memData got=%h exp=abcd0000", memData); end
    checks++; if (memMask !== 4'b1100) begin failures++; $display("FAIL single_memMask got=%b exp=1100", memMask); end
    checks++; if (bufCount !== 3'd1) begin failures++; $display("FAIL single_bufCount got=%0d exp=1", bufCount); end
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      checks++;
      if ({memValid, memAddress, memData, memMask} !== {1'b1, 32'h1000_0004, 32'hABCD_0000, 4'b1100}) begin
        failures++;
        $display("FAIL single_hold cycle=%0d got=%b/%h/%h/%b exp=1/10000004/abcd0000/1100", i, memValid, memAddress, memData, memMask);
      end
    end
    memReady = 1'b1;
    tick();
    memReady = 1'b0;
    #1;
    checks++; if (bufEmpty !== 1'b1) begin failures++; $display("FAIL single_drained got=%b exp=1", bufEmpty); end
  endtask

  task automatic test_fill_drain();
    logic [31:0] d [4];
    logic [3:0]  m [4];
    drive_idle();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        d[i] = $urandom;
        m[i] = 4'($urandom_range(1, 15));
        drive_enq(32'h100 + 32'(4 * i), d[i], m[i]);
        tick();
      end
      enqValid = 1'b0;
      #1;
      checks++; if (bufCount !== 3'd4) begin failures++; $display("FAIL full_bufCount round=%0d got=%0d exp=4", r, bufCount); end
      checks++; if (enqReady !== 1'b0) begin failures++; $display("FAIL full_enqReady round=%0d got=%b exp=0", r, enqReady); end
      drive_enq(32'h110, 32'hDEAD_BEEF, 4'b1111);
      tick();
      enqValid = 1'b0;
      #1;
      checks++; if (bufCount !== 3'd4) begin failures++; $display("FAIL full_fifth_rejected round=%0d got=%0d exp=4", r, bufCount); end
      memReady = 1'b1;
      for (int i = 0; i < 4; i++) begin
        #1;
        checks++;
        if ({memValid, memAddress, memData, memMask} !== {1'b1, 32'h100 + 32'(4 * i), d[i], m[i]}) begin
          failures++;
          $display("FAIL drain_order round=%0d idx=%0d got=%b/%h/%h/%b exp=1/%h/%h/%b", r, i, memValid, memAddress, memData, memMask, 32'h100 + 32'(4 * i), d[i], m[i]);
        end
        tick();
      end
      memReady = 1'b0;
      #1;
      checks++; if (bufEmpty !== 1'b1) begin failures++; $display("FAIL drain_empty round=%0d got=%b exp=1", r, bufEmpty); end
    end
  endtask

  task automatic test_back_to_back();
    drive_idle();
    drive_enq(32'h300, 32'h1111_1111, 4'b1111); tick();
    drive_enq(32'h304, 32'h2222_2222, 4'b1111); tick();
    drive_enq(32'h308, 32'h3333_3333, 4'b1111);
    memReady = 1'b1;
    tick();
    enqValid = 1'b0;
    memReady = 1'b0;
    #1;
    checks++; if (bufCount !== 3'd2) begin failures++; $display("FAIL b2b_count2 got=%0d exp=2", bufCount); end
    checks++; if (memAddress !== 32'h304) begin failures++; $display("FAIL b2b_head_old_second got=%h exp=304", memAddress); end
    memReady = 1'b1;
    tick();
    #1;
    checks++; if (memAddress !== 32'h308 || memData !== 32'h3333_3333) begin failures++; $display("FAIL b2b_head_new got=%h/%h exp=308/33333333", memAddress, memData); end
    // count==1: simultaneous enqueue and dequeue makes the new entry head
    drive_enq(32'h30C, 32'h4444_4444, 4'b0101);
    tick();
    enqValid = 1'b0;
    memReady = 1'b0;
    #1;
    checks++; if (bufCount !== 3'd1) begin failures++; $display("FAIL b2b_count1 got=%0d exp=1", bufCount); end
    checks++; if (memAddress !== 32'h30C || memMask !== 4'b0101) begin failures++; $display("FAIL b2b_count1_head got=%h/%b exp=30c/0101", memAddress, memMask); end
    memReady = 1'b1;
    tick();
    memReady = 1'b0;
    #1;
    checks++; if (bufEmpty !== 1'b1) begin failures++; $display("FAIL b2b_empty got=%b exp=1", bufEmpty); end
  endtask

  task automatic test_zero_mask();
    drive_idle();
    drive_enq(32'h500, 32'h5555_5555, 4'b0000);
    #1;
    checks++; if (enqReady !== 1'b1) begin failures++; $display("FAIL zmask_ready got=%b exp=1", enqReady); end
    tick();
    enqValid         = 1'b0;
    loadCheckAddress = 32'h500;
    loadCheckMask    = 4'b1111;
    #1;
    checks++; if (bufCount !== 3'd0) begin failures++; $display("FAIL zmask_count got=%0d exp=0", bufCount); end
    checks++; if (memValid !== 1'b0) begin failures++; $display("FAIL zmask_memValid got=%b exp=0", memValid); end
    checks++; if (loadHazard !== 1'b0) begin failures++; $display("FAIL zmask_hazard got=%b exp=0", loadHazard); end
  endtask

  task automatic test_hazard();
    drive_idle();
    drive_enq(32'h200, 32'h0000_ABCD, 4'b0011);
    tick();
    enqValid = 1'b0;
    loadCheckAddress = 32'h202; loadCheckMask = 4'b1100;
    #1;
    checks++; if (loadHazard !== 1'b0) begin failures++; $display("FAIL hz_disjoint_lanes got=%b exp=0", loadHazard); end
    loadCheckAddress = 32'h201; loadCheckMask = 4'b0010;
    #1;
    checks++; if (loadHazard !== 1'b1) begin failures++; $display("FAIL hz_overlap got=%b exp=1", loadHazard); end
    loadCheckAddress = 32'h204; loadCheckMask = 4'b1111;
    drive_enq(32'h204, 32'h1234_5678, 4'b1111);
    #1;
    checks++; if (loadHazard !== 1'b0) begin failures++; $display("FAIL hz_same_cycle_enq got=%b exp=0", loadHazard); end
    tick();
    enqValid = 1'b0;
    #1;
    checks++; if (loadHazard !== 1'b1) begin failures++; $display("FAIL hz_after_enq got=%b exp=1", loadHazard); end
    loadCheckAddress = 32'h201; loadCheckMask = 4'b0010;
    memReady = 1'b1;
    #1;
    checks++; if (loadHazard !== 1'b1) begin failures++; $display("FAIL hz_head_handshaking got=%b exp=1", loadHazard); end
    tick();
    #1;
    checks++; if (loadHazard !== 1'b0) begin failures++; $display("FAIL hz_after_drain got=%b exp=0", loadHazard); end
    tick();
    memReady = 1'b0;
    // reset with three pending stores while the head is handshaking
    drive_enq(32'h600, 32'h6, 4'b1111); tick();
    drive_enq(32'h604, 32'h7, 4'b1111); tick();
    drive_enq(32'h608, 32'h8, 4'b1111); tick();
    enqValid = 1'b0;
    #1;
    checks++; if (bufCount !== 3'd3) begin failures++; $display("FAIL rst_pre_count got=%0d exp=3", bufCount); end
    rst = 1'b1;
    memReady = 1'b1;
    tick();
    rst = 1'b0;
    memReady = 1'b0;
    loadCheckAddress = 32'h604; loadCheckMask = 4'b1111;
    #1;
    checks++; if (bufCount !== 3'd0) begin failures++; $display("FAIL rst_mid_count got=%0d exp=0", bufCount); end
    checks++; if (memValid !== 1'b0) begin failures++; $display("FAIL rst_mid_memValid got=%b exp=0", memValid); end
    checks++; if (loadHazard !== 1'b0) begin failures++; $display("FAIL rst_mid_hazard got=%b exp=0", loadHazard); end
  endtask

  task automatic test_random();
    logic exp_h;
    entry_t h;
    drive_idle();
    for (int c = 0; c < 400; c++) begin
      enqValid         = ($urandom_range(0, 3) != 0);
      enqAddress       = 32'h400 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
      enqData          = $urandom;
      enqMask          = 4'($urandom_range(0, 15));
      memReady         = ($urandom_range(0, 2) == 0);
      loadCheckAddress = 32'h400 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
      loadCheckMask    = 4'($urandom_range(0, 15));
      #1;
      checks++;
      if (enqReady !== (exp_q.size() != DEPTH) || memValid !== (exp_q.size() != 0)
          || bufEmpty !== (exp_q.size() == 0) || bufCount !== 3'(exp_q.size())) begin
        failures++;
        $display("FAIL rand_status cycle=%0d got=r%b v%b e%b n%0d exp_count=%0d", c, enqReady, memValid, bufEmpty, bufCount, exp_q.size());
      end
      exp_h = model_hazard(loadCheckAddress, loadCheckMask);
      checks++;
      if (loadHazard !== exp_h) begin
        failures++;
        $display("FAIL rand_hazard cycle=%0d got=%b exp=%b", c, loadHazard, exp_h);
      end
      if (exp_q.size() > 0) begin
        h = exp_q[0];
        checks++;
        if ({memAddress, memData, memMask} !== {h.waddr, 2'b00, h.data, h.mask}) begin
          failures++;
          $display("FAIL rand_head cycle=%0d got=%h/%h/%b exp=%h/%h/%b", c, memAddress, memData, memMask, {h.waddr, 2'b00}, h.data, h.mask);
        end
      end
      tick();
    end
    drive_idle();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    drive_idle();
    test_reset();
    test_single();
    test_fill_drain();
    test_back_to_back();
    test_zero_mask();
    test_hazard();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
